// File: rtl/hc138_scan_ctrl.sv
// hc138_scan_ctrl: scan sequencer for a 74HC138 3-to-8 decoder.
// Steps a slot index through DIGITS slots of DIV cycles each, blanking the
// decoder for the first BLANK cycles of every slot to hide ghosting.
// Optional feature macro: HC138_MASK_EN adds the Mask port for per-slot gating.
//
//   state | meaning
//   IDLE  | decoder disabled, Sel=0, idx=0, cnt=0
//   SCAN  | stepping slots, Sel=idx, drive after the blanking window
module hc138_scan_ctrl #(
  parameter int DIV    = 4,
  parameter int BLANK  = 1,
  parameter int DIGITS = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Run,
`ifdef HC138_MASK_EN
  input  logic [7:0] Mask,
`endif
  output logic [2:0] Sel,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       FrameDone
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drive_q, drive_d;
  logic          fd_q, fd_d;
  logic [7:0]    slot_mask;
  logic          past_blank;

`ifdef HC138_MASK_EN
  assign slot_mask = Mask;
`else
  assign slot_mask = 8'hFF;
`endif

  // Next slot position plus the output values for that position, so that the
  // output flops always line up with idx_q/cnt_q.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!Run) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = SCAN;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // cnt >= BLANK written as cnt+1 > BLANK so BLANK=0 is not a constant-true compare
    past_blank = (32'(cnt_d) + 32'd1) > 32'(BLANK);
    drive_d    = (state_d == SCAN) && past_blank && slot_mask[idx_d];
    fd_d       = (state_d == SCAN) && (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      drive_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drive_q <= drive_d;
      fd_q    <= fd_d;
    end
  end

  assign Sel       = idx_q;
  assign E3        = drive_q;
  assign E1        = ~drive_q;
  assign E2        = ~drive_q;
  assign FrameDone = fd_q;

endmodule

// File: doc/hc138_scan_ctrl.md
HC138_SCAN_CTRL -- requirements
Module: hc138_scan_ctrl

Interface
REQ-001 Parameter DIV, default 4: clock cycles per scan slot; legal range 2..65535.
REQ-002 Parameter BLANK, default 1: decoder-disabled cycles at the start of each slot; legal range 0..DIV-1.
REQ-003 Parameter DIGITS, default 8: number of slots per frame; legal range 1..8.
REQ-004 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Rst  input  1  reset, synchronous and active-high.
REQ-006 Run  input  1  scan enable; 1 = scanning, 0 = idle.
REQ-007 Mask  input  8  per-slot drive enable, bit i gates slot i (present only with HC138_MASK_EN).
REQ-008 Sel  output  3  slot index, drives the 3-to-8 decoder select input.
REQ-009 E1  output  1  decoder enable, active-low.
REQ-010 E2  output  1  decoder enable, active-low.
REQ-011 E3  output  1  decoder enable, active-high.
REQ-012 FrameDone  output  1  one-cycle pulse on the final cycle of each frame.

Function
REQ-013 The block SHALL hold a slot index idx (0..DIGITS-1) and a cycle counter cnt (0..DIV-1); all outputs SHALL be registered.
REQ-014 Drive state: E1=0, E2=0, E3=1. Disabled state: E1=1, E2=1, E3=0. E1 and E2 SHALL always be equal and SHALL be the inverse of E3.
REQ-015 States: IDLE (outputs disabled, Sel=0, idx=0, cnt=0) and SCAN.
REQ-016 In IDLE, Run=1 sampled at edge k SHALL enter SCAN. The output cycle after edge k SHALL be slot 0 with cnt=0.
REQ-017 In SCAN, Sel SHALL equal idx for all DIV cycles of the slot.
REQ-018 In SCAN, the outputs SHALL be disabled for cnt < BLANK and in the drive state for cnt >= BLANK. BLANK=0 therefore yields continuous drive.
REQ-019 In SCAN, cnt SHALL increment every cycle.
REQ-020 At cnt=DIV-1, cnt SHALL wrap to 0 and idx SHALL advance; idx=DIGITS-1 SHALL wrap to 0.
REQ-021 FrameDone SHALL be 1 exactly in the output cycle where idx=DIGITS-1 and cnt=DIV-1, and 0 otherwise.
REQ-022 Run=0 sampled in SCAN at any cnt SHALL return the block to IDLE values in the next output cycle, with no slot completion and no FrameDone.
REQ-023 Run=1 continuously SHALL give a frame period of exactly DIGITS*DIV cycles, with no idle gap between frames.
REQ-024 Rst=1 and Run=1 sampled on the same edge: Rst SHALL win.

Reset
REQ-025 Rst=1 SHALL force the following on the next edge: IDLE, idx=0, cnt=0, Sel=0, E1=1, E2=1, E3=0, FrameDone=0.
REQ-026 After Rst is released with Run=1, scanning SHALL begin per REQ-016.
REQ-027 Rst asserted mid-slot or mid-frame SHALL discard all progress.

Configuration
REQ-028 Macro HC138_MASK_EN defined:
- the Mask port SHALL exist;
- a slot whose Mask[idx]=0 SHALL still consume DIV cycles but SHALL keep the outputs disabled throughout;
- Mask SHALL be sampled every cycle;
- Sel and FrameDone timing SHALL be unchanged by Mask;
- Mask=8'h00 SHALL keep the decoder disabled continuously.
REQ-029 Macro HC138_MASK_EN undefined: the Mask port SHALL be absent and every slot SHALL be driven as if Mask=8'hFF.

Verification (DIV=4, BLANK=1, DIGITS=8 unless stated)
REQ-030 Reset: Rst=1 for 2 cycles -> Sel=0, E1=1, E2=1, E3=0, FrameDone=0.
REQ-031 Continuous run: Run=1 for 70 cycles ->
- Sel steps 0..7, each value held 4 cycles;
- E3 pattern 0,1,1,1 per slot;
- FrameDone pulses at cycles 32 and 64 after Run is sampled.
REQ-032 Abort and restart: Run dropped at idx=3, cnt=2 -> next cycle shows IDLE values; Run reasserted -> Sel=0 with E3=0 for the first cycle.
REQ-033 No blanking: BLANK=0, DIGITS=3 -> Sel sequence 0,1,2,0 with 4 cycles each, E3 constantly 1, FrameDone every 12 cycles.
REQ-034 Mask (HC138_MASK_EN defined): Mask=8'b0000_0101 -> E3 high only during cnt 1..3 of slots 0 and 2; Sel and FrameDone identical to REQ-031.
REQ-035 Reset mid-frame: Rst=1 at idx=5 with Run=1 held -> reset values on the next cycle; after Rst is released, slot 0 starts with cnt=0 and no FrameDone pulse.
